// File: rtl/mnist_pkg.sv
// Shared constants and feeder state encoding for the MNIST pixel feeder.
// Image geometry defaults are the 28x28 8-bit MNIST format.
package mnist_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int NUM_PIX    = IMG_W * IMG_H;
  localparam int PIX_BITS   = 8;
  localparam int CLASS_BITS = 4;
  localparam int WAIT_MAX   = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FULL   = 3'd2,
    ST_STREAM = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } feeder_state_t;

endpackage

// File: rtl/mnist_pix_ram.sv
// Single-write / single-read synchronous pixel buffer with a registered read port.
// Contents are not reset so an image survives a reset of the feeder.
module mnist_pix_ram #(
  parameter int DEPTH = 784,
  parameter int W     = 8,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mnist_pixel_feeder.sv
// Loads one image from the host, streams it to the CNN one pixel per clock, latches the class.
// Optional WAIT timeout is enabled by defining FEEDER_TIMEOUT_EN.
//
// Handshakes: wr_en, start and cnn_valid are single-cycle strobes sampled on the rising
// edge; there is no back-pressure, so a strobe outside its accepting states is dropped.
module mnist_pixel_feeder
  import mnist_pkg::*;
#(
  parameter int IMG_W    = mnist_pkg::IMG_W,
  parameter int IMG_H    = mnist_pkg::IMG_H,
  parameter int PIX_BITS = mnist_pkg::PIX_BITS,
  parameter int WAIT_MAX = mnist_pkg::WAIT_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [PIX_BITS-1:0]   wr_data,
  input  logic                  start,
  output logic [PIX_BITS-1:0]   pix_data,
  output logic                  cnn_go,
  input  logic [CLASS_BITS-1:0] cnn_decision,
  input  logic                  cnn_valid,
  output logic [CLASS_BITS-1:0] result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  buf_full,
  output logic                  timeout,
  output logic [2:0]            dbg_state
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  feeder_state_t state, next_state;

  logic [AW-1:0]       wr_ptr, rd_ptr, waddr;
  logic                issue_done, q_vld, q_last, out_last;
  logic                we, re, wr_acc, start_acc, wait_expired;
  logic [PIX_BITS-1:0] ram_q;

  mnist_pix_ram #(.DEPTH(NPIX), .W(PIX_BITS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wr_data),
    .re    (re),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

`ifdef FEEDER_TIMEOUT_EN
  localparam int WCW = $clog2(WAIT_MAX + 1);
  logic [WCW-1:0] wait_cnt;
  assign wait_expired = (wait_cnt == WCW'(WAIT_MAX - 1));
`else
  assign wait_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    next_state = state;
    wr_acc     = 1'b0;
    start_acc  = 1'b0;
    case (state)
      ST_IDLE, ST_FULL, ST_DONE: begin
        // start has priority; any write here begins a fresh image at address 0
        if (start && buf_full) begin
          start_acc  = 1'b1;
          next_state = ST_STREAM;
        end else if (wr_en) begin
          wr_acc     = 1'b1;
          next_state = ST_LOAD;
        end else if (state == ST_DONE) begin
          next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (wr_en) begin
          wr_acc = 1'b1;
          if (wr_ptr == LAST) next_state = ST_FULL;
        end
      end
      ST_STREAM: if (out_last) next_state = ST_WAIT;
      ST_WAIT: begin
        if (cnn_valid)         next_state = ST_DONE;
        else if (wait_expired) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign we        = wr_acc;
  assign waddr     = (state == ST_LOAD) ? wr_ptr : '0;
  assign re        = (state == ST_STREAM) && !issue_done;
  assign busy      = (state == ST_STREAM) || (state == ST_WAIT);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      issue_done   <= 1'b0;
      q_vld        <= 1'b0;
      q_last       <= 1'b0;
      out_last     <= 1'b0;
      pix_data     <= '0;
      cnn_go       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      buf_full     <= 1'b0;
    end else begin
      state <= next_state;

      if (wr_acc) begin
        result_valid <= 1'b0;
        if (state == ST_LOAD) begin
          if (wr_ptr == LAST) buf_full <= 1'b1;
          else                wr_ptr   <= wr_ptr + 1'b1;
        end else begin
          wr_ptr   <= AW'(1);
          buf_full <= 1'b0;
        end
      end

      if (start_acc) begin
        rd_ptr       <= '0;
        issue_done   <= 1'b0;
        result_valid <= 1'b0;
      end else if (re) begin
        if (rd_ptr == LAST) issue_done <= 1'b1;
        else                rd_ptr     <= rd_ptr + 1'b1;
      end

      // two-stage read pipe: RAM register, then output register
      q_vld    <= re;
      q_last   <= re && (rd_ptr == LAST);
      out_last <= q_last;
      pix_data <= q_vld ? ram_q : '0;
      cnn_go   <= ((next_state == ST_STREAM) && q_vld) || (next_state == ST_WAIT);

      if ((state == ST_WAIT) && cnn_valid) begin
        result       <= cnn_decision;
        result_valid <= 1'b1;
      end
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (start_acc) timeout <= 1'b0;
      if (state != ST_WAIT) begin
        wait_cnt <= '0;
      end else if (!cnn_valid) begin
        if (wait_expired) timeout  <= 1'b1;
        else              wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mnist_pixel_feeder.sv
// Self-checking bench for mnist_pixel_feeder: image model plus per-cycle stream compare.
// Define FEEDER_TIMEOUT_EN to also exercise the WAIT timeout with WAIT_MAX=16.
module tb_mnist_pixel_feeder;

  localparam int NPIX = 784;
`ifdef FEEDER_TIMEOUT_EN
  localparam int TB_WAIT = 16;
`else
  localparam int TB_WAIT = 4096;
`endif

  logic       clk = 1'b0;
  logic       rst, wr_en, start, cnn_valid;
  logic [7:0] wr_data;
  logic [3:0] cnn_decision;
  logic [7:0] pix_data;
  logic       cnn_go, result_valid, busy, buf_full, timeout;
  logic [3:0] result;
  logic [2:0] dbg_state;

  mnist_pixel_feeder #(.WAIT_MAX(TB_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .start        (start),
    .pix_data     (pix_data),
    .cnn_go       (cnn_go),
    .cnn_decision (cnn_decision),
    .cnn_valid    (cnn_valid),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .buf_full     (buf_full),
    .timeout      (timeout),
    .dbg_state    (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model: loaded image, full flag, expected stream queue and its start cycle
  logic [7:0] m_img [NPIX];
  logic [7:0] exp_q [$];
  logic       m_full = 1'b0;
  logic       s_on   = 1'b0;
  logic       chk_en = 1'b0;
  int         s_cyc  = 0;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // stream compare: pixel k of the snapshot must be on pix_data 2+k cycles after start edge
  always @(negedge clk) begin
    int k;
    if (chk_en) begin
      k = cyc - s_cyc - 2;
      if (s_on && k >= 0 && k < NPIX) begin
        chk("stream_pix", pix_data, exp_q[k]);
        chk("stream_go", cnn_go, 1);
      end else begin
        chk("pix_idle_zero", pix_data, 0);
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (m_full) begin
      exp_q.delete();
      for (int i = 0; i < NPIX; i++) exp_q.push_back(m_img[i]);
      s_cyc = cyc;
      s_on  = 1'b1;
    end
  endtask

  task automatic load_image(input int mul, input int add);
    for (int i = 0; i < NPIX; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'((i * mul + add) % 256);
      m_img[i] = wr_data;
      @(posedge clk); #1;
      if (i == NPIX - 2) chk("buf_full_before_last", buf_full, 0);
    end
    wr_en  = 1'b0;
    m_full = 1'b1;
    chk("buf_full_after_last", buf_full, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix"}, pix_data, 0);
    chk({tag, "_go"}, cnn_go, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_rvalid"}, result_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_full"}, buf_full, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_state"}, dbg_state, 32'(mnist_pkg::ST_IDLE));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0;
    cnn_valid = 1'b0; cnn_decision = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");
    chk_en = 1'b1;

    // start with empty buffer is dropped
    do_start();
    chk("start_empty_busy", busy, 0);
    repeat (4) @(posedge clk); #1;
    chk("start_empty_go", cnn_go, 0);

    // load value = index mod 256
    load_image(1, 0);

    // stream, with writes/starts/cnn_valid injected mid-stream
    do_start();
    chk("busy_after_start", busy, 1);
    chk("go_before_pix0", cnn_go, 0);
    wait_to(s_cyc + 10);
    wr_en = 1'b1; wr_data = 8'hAA; start = 1'b1;
    wait_to(s_cyc + 14);
    wr_en = 1'b0; start = 1'b0;
    wait_to(s_cyc + 50);
    cnn_valid = 1'b1; cnn_decision = 4'd3;
    wait_to(s_cyc + 51);
    cnn_valid = 1'b0;
    wait_to(s_cyc + 2 + 300);
    chk("pix300_literal", pix_data, 44);
    wait_to(s_cyc + 2 + 783);
    chk("pix783_literal", pix_data, 15);
    chk("mid_stream_rvalid", result_valid, 0);
    wait_to(s_cyc + 2 + 784);
    chk("wait_go", cnn_go, 1);
    chk("wait_busy", busy, 1);
    wait_to(s_cyc + 2 + 794);
    chk("wait_no_timeout", timeout, 0);
    chk("wait_go_late", cnn_go, 1);
    cnn_valid = 1'b1; cnn_decision = 4'd7;
    @(posedge clk); #1;
    cnn_valid = 1'b0;
    s_on = 1'b0;
    chk("result", result, 7);
    chk("result_valid", result_valid, 1);
    chk("done_go", cnn_go, 0);
    chk("done_busy", busy, 0);
    @(posedge clk); #1;
    chk("back_to_idle", dbg_state, 32'(mnist_pkg::ST_IDLE));
    chk("full_kept", buf_full, 1);
    chk("result_held", result, 7);

    // re-stream the same image, reset at pixel 400
    do_start();
    chk("restart_clears_rvalid", result_valid, 0);
    chk("restart_busy", busy, 1);
    wait_to(s_cyc + 2 + 400);
    chk("pix400_literal", pix_data, 144);
    rst = 1'b1;
    @(posedge clk); #1;
    s_on = 1'b0;
    m_full = 1'b0;
    check_reset_outputs("midrst");
    rst = 1'b0;
    do_start();
    chk("start_after_rst_busy", busy, 0);

`ifdef FEEDER_TIMEOUT_EN
    // reload a different image; let WAIT expire with no cnn_valid
    load_image(3, 5);
    do_start();
    wait_to(s_cyc + 801);
    chk("timeout_pre", timeout, 0);
    wait_to(s_cyc + 802);
    chk("timeout_set", timeout, 1);
    chk("timeout_go", cnn_go, 0);
    chk("timeout_rvalid", result_valid, 0);
    chk("timeout_idle", dbg_state, 32'(mnist_pkg::ST_IDLE));
    s_on = 1'b0;
    do_start();
    chk("timeout_cleared", timeout, 0);
    wait_to(s_cyc + 2 + 784);
    s_on = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
